// File: rtl/axi_user_bridge_pkg.sv
// Shared encodings for the MEM-stage AXI user bridge: FSM states and fixed AXI4 field values.
package axi_user_bridge_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_ADDR  = 3'd1;
  localparam logic [2:0] ST_RD_DATA  = 3'd2;
  localparam logic [2:0] ST_WR_WAITD = 3'd3;
  localparam logic [2:0] ST_WR_ADDR  = 3'd4;
  localparam logic [2:0] ST_WR_RESP  = 3'd5;

  localparam logic [2:0] SIZE_WORD   = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [7:0] LEN_SINGLE  = 8'd0;
  localparam logic [3:0] STRB_WORD   = 4'hF;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_user_bridge.sv
// Single-outstanding AXI4 master bridge for the MEM-stage user interface.
// Each user request becomes one 32-bit single-beat AR/R or AW/W/B transaction.
module axi_user_bridge
  import axi_user_bridge_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            axi_start,
  input  logic            axi_rw,
  input  logic [31:0]     axi_addr,
  input  logic [31:0]     axi_wdata,
  input  logic            axi_wvalid,
  output logic            axi_wready,
  output logic [31:0]     axi_rdata,
  output logic            axi_done,
  output logic            axi_busy,
  output logic            axi_err,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  // state       | meaning
  // ST_IDLE     | waiting for axi_start
  // ST_RD_ADDR  | arvalid up, waiting for arready
  // ST_RD_DATA  | rready up, waiting for rvalid
  // ST_WR_WAITD | store address latched, waiting for axi_wvalid
  // ST_WR_ADDR  | AW and W issued independently, each with a sticky done flag
  // ST_WR_RESP  | bready up, waiting for bvalid

  logic [2:0]  state, state_n;
  logic        aw_done, aw_done_n;
  logic        w_done, w_done_n;
  logic        done_n, err_n;
  logic [31:0] araddr_n, awaddr_n, wdata_n, rdata_n;
  logic        unused_inputs;

  assign unused_inputs = ^{rid, rlast, bid};

  assign arid    = '0;
  assign arlen   = LEN_SINGLE;
  assign arsize  = SIZE_WORD;
  assign arburst = BURST_INCR;
  assign awid    = '0;
  assign awlen   = LEN_SINGLE;
  assign awsize  = SIZE_WORD;
  assign awburst = BURST_INCR;
  assign wstrb   = STRB_WORD;
  assign wlast   = 1'b1;

  always_comb begin
    state_n   = state;
    aw_done_n = 1'b0;
    w_done_n  = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    araddr_n  = araddr;
    awaddr_n  = awaddr;
    wdata_n   = wdata;
    rdata_n   = axi_rdata;
    case (state)
      ST_IDLE: begin
        if (axi_start) begin
          if (axi_rw) begin
            araddr_n = axi_addr;
            state_n  = ST_RD_ADDR;
          end else begin
            awaddr_n = axi_addr;
            if (axi_wvalid) begin
              wdata_n = axi_wdata;
              state_n = ST_WR_ADDR;
            end else begin
              state_n = ST_WR_WAITD;
            end
          end
        end
      end
      ST_RD_ADDR: begin
        if (arvalid && arready) state_n = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (rvalid) begin
          rdata_n = rdata;
          done_n  = 1'b1;
          err_n   = resp_is_err(rresp);
          state_n = ST_IDLE;
        end
      end
      ST_WR_WAITD: begin
        if (axi_wvalid) begin
          wdata_n = axi_wdata;
          state_n = ST_WR_ADDR;
        end
      end
      ST_WR_ADDR: begin
        // flags merge this cycle's handshakes so simultaneous AW/W completion exits at once
        aw_done_n = aw_done | (awvalid & awready);
        w_done_n  = w_done | (wvalid & wready);
        if (aw_done_n && w_done_n) begin
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          state_n   = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (bvalid) begin
          done_n  = 1'b1;
          err_n   = resp_is_err(bresp);
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // every output is a flop driven from the next-state decode
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      axi_wready <= 1'b1;
      axi_busy   <= 1'b0;
      axi_done   <= 1'b0;
      axi_err    <= 1'b0;
      axi_rdata  <= '0;
      araddr     <= '0;
      awaddr     <= '0;
      wdata      <= '0;
    end else begin
      state      <= state_n;
      aw_done    <= aw_done_n;
      w_done     <= w_done_n;
      arvalid    <= (state_n == ST_RD_ADDR);
      rready     <= (state_n == ST_RD_DATA);
      awvalid    <= (state_n == ST_WR_ADDR) && !aw_done_n;
      wvalid     <= (state_n == ST_WR_ADDR) && !w_done_n;
      bready     <= (state_n == ST_WR_RESP);
      axi_wready <= (state_n == ST_IDLE) || (state_n == ST_WR_WAITD);
      axi_busy   <= (state_n != ST_IDLE);
      axi_done   <= done_n;
      axi_err    <= err_n;
      axi_rdata  <= rdata_n;
      araddr     <= araddr_n;
      awaddr     <= awaddr_n;
      wdata      <= wdata_n;
    end
  end

endmodule

// File: tb/tb_axi_user_bridge.sv
// Scoreboard bench for axi_user_bridge: randomized AXI slave, reference memory model,
// expectation queue popped by a monitor on every axi_done.
module tb_axi_user_bridge;

  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic            axi_start, axi_rw, axi_wvalid;
  logic [31:0]     axi_addr, axi_wdata;
  logic            axi_wready, axi_done, axi_busy, axi_err;
  logic [31:0]     axi_rdata;
  logic [ID_W-1:0] arid, rid, awid, bid;
  logic [31:0]     araddr, rdata, awaddr, wdata;
  logic [7:0]      arlen, awlen;
  logic [2:0]      arsize, awsize;
  logic [1:0]      arburst, awburst, rresp, bresp;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]      wstrb;

  axi_user_bridge #(.ID_W(ID_W)) dut (
    .clk(clk), .resetn(resetn),
    .axi_start(axi_start), .axi_rw(axi_rw), .axi_addr(axi_addr), .axi_wdata(axi_wdata),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_rdata(axi_rdata),
    .axi_done(axi_done), .axi_busy(axi_busy), .axi_err(axi_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          rw;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          start_cyc;
    int          exp_lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_ar_q[$];
  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_w_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] last_rdata = '0;

  // slave contents: unwritten words read back a pattern of their address; 0xF region errors
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return (a[31:28] == 4'hF) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  // ---------------- AXI slave ----------------
  bit          zero_wait = 1'b1;
  int          aw_hold = 0;
  int          r_extra = 0;
  bit          rd_pending = 1'b0;
  int          r_delay = 0;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  bit          aw_got = 1'b0, w_got = 1'b0;
  int          b_delay = 0;
  logic [1:0]  b_resp;
  logic [31:0] aw_addr_l, w_data_l;
  logic [31:0] slv_mem[logic [31:0]];
  int          ar_count = 0, aw_count = 0, w_count = 0, done_count = 0;

  function automatic logic pick_ready();
    if (zero_wait) return 1'b1;
    return ($urandom_range(0, 2) != 0);
  endfunction

  function automatic int pick_delay();
    if (zero_wait) return 0;
    return int'($urandom_range(0, 3));
  endfunction

  // inputs change at negedge; a handshake decided here lands on the following posedge
  initial begin
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rid = '0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; bid = '0;
    forever begin
      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0;
      if (rd_pending) begin
        if (r_delay > 0) r_delay--;
        else begin
          rvalid = 1'b1; rlast = 1'b1; rdata = r_data; rresp = r_resp;
          rid = 4'($urandom);
          if (rready) rd_pending = 1'b0;
        end
      end
      bvalid = 1'b0;
      if (aw_got && w_got) begin
        if (b_delay > 0) b_delay--;
        else begin
          bvalid = 1'b1; bresp = b_resp; bid = 4'($urandom);
          if (bready) begin
            if (b_resp == 2'b00) slv_mem[aw_addr_l] = w_data_l;
            aw_got = 1'b0; w_got = 1'b0;
          end
        end
      end
      arready = 1'b0;
      if (arvalid && !rd_pending) begin
        arready = pick_ready();
        if (arready) begin
          ar_count++;
          chk("ar_fixed", 32'({arid, arlen, arsize, arburst}), 32'h00000009);
          if (exp_ar_q.size() == 0) chk("ar_unexpected", 32'(ar_count), 32'(0));
          else chk("araddr", araddr, exp_ar_q.pop_front());
          r_data = slv_mem.exists(araddr) ? slv_mem[araddr] : dflt(araddr);
          r_resp = resp_of(araddr);
          r_delay = pick_delay() + r_extra;
          rd_pending = 1'b1;
        end
      end
      awready = 1'b0;
      if (awvalid && !aw_got) begin
        if (aw_hold > 0) aw_hold--;
        else awready = pick_ready();
        if (awready) begin
          aw_count++;
          chk("aw_fixed", 32'({awid, awlen, awsize, awburst}), 32'h00000009);
          if (exp_aw_q.size() == 0) chk("aw_unexpected", 32'(aw_count), 32'(0));
          else chk("awaddr", awaddr, exp_aw_q.pop_front());
          aw_addr_l = awaddr;
          b_resp = resp_of(awaddr);
          b_delay = pick_delay();
          aw_got = 1'b1;
        end
      end
      wready = 1'b0;
      if (wvalid && !w_got) begin
        wready = pick_ready();
        if (wready) begin
          w_count++;
          chk("w_fixed", 32'({wstrb, wlast}), 32'h0000001F);
          if (exp_w_q.size() == 0) chk("w_unexpected", 32'(w_count), 32'(0));
          else chk("wdata", wdata, exp_w_q.pop_front());
          w_data_l = wdata;
          w_got = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (axi_err) chk("err_with_done", 32'(axi_done), 32'(1));
      if (axi_done) begin
        done_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(axi_done), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk(e.rw ? "load_rdata" : "store_rdata_held", axi_rdata, e.exp_rdata);
          chk("axi_err", 32'(axi_err), 32'(e.exp_err));
          chk("idle_at_done", 32'(axi_busy), 32'(0));
          if (e.exp_lat > 0) chk("done_latency", 32'(cyc - e.start_cyc), 32'(e.exp_lat));
        end
      end
    end
  end

  // valid must hold with stable payload until its handshake, then drop (single beat)
  initial begin
    bit          p_arv = 0, p_awv = 0, p_wv = 0;
    logic [31:0] p_ara, p_awa, p_wd;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        p_arv = 0; p_awv = 0; p_wv = 0;
      end else begin
        if (p_arv) begin
          if (arready) chk("arvalid_drop", 32'(arvalid), 32'(0));
          else begin
            chk("arvalid_hold", 32'(arvalid), 32'(1));
            chk("araddr_stable", araddr, p_ara);
          end
        end
        if (p_awv) begin
          if (awready) chk("awvalid_drop", 32'(awvalid), 32'(0));
          else begin
            chk("awvalid_hold", 32'(awvalid), 32'(1));
            chk("awaddr_stable", awaddr, p_awa);
          end
        end
        if (p_wv) begin
          if (wready) chk("wvalid_drop", 32'(wvalid), 32'(0));
          else begin
            chk("wvalid_hold", 32'(wvalid), 32'(1));
            chk("wdata_stable", wdata, p_wd);
          end
        end
        p_arv = arvalid; p_ara = araddr;
        p_awv = awvalid; p_awa = awaddr;
        p_wv  = wvalid;  p_wd  = wdata;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n = 0;
    while ((axi_busy || exp_q.size() != 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("idle_timeout", 32'(axi_busy), 32'(0));
  endtask

  task automatic issue(input bit rw, input logic [31:0] addr, input logic [31:0] data,
                       input int lag, input int exp_lat);
    exp_t e;
    wait_idle();
    e.rw = rw; e.start_cyc = cyc; e.exp_lat = exp_lat;
    e.exp_err = (resp_of(addr) != 2'b00);
    if (rw) begin
      e.exp_rdata = ref_load(addr);
      last_rdata = e.exp_rdata;
      exp_ar_q.push_back(addr);
    end else begin
      e.exp_rdata = last_rdata;
      exp_aw_q.push_back(addr);
      exp_w_q.push_back(data);
      if (!e.exp_err) ref_mem[addr] = data;
    end
    exp_q.push_back(e);
    axi_start = 1'b1; axi_rw = rw; axi_addr = addr;
    axi_wdata  = (rw || lag == 0) ? data : $urandom;
    axi_wvalid = rw ? 1'($urandom_range(0, 1)) : (lag == 0);
    @(posedge clk); #1;
    axi_start = 1'b0; axi_wvalid = 1'b0; axi_addr = $urandom; axi_wdata = $urandom;
    if (!rw && lag > 0) begin
      for (int i = 1; i < lag; i++) begin
        chk("wready_waiting", 32'(axi_wready), 32'(1));
        @(posedge clk); #1;
      end
      chk("wready_waiting", 32'(axi_wready), 32'(1));
      axi_wvalid = 1'b1; axi_wdata = data;
      @(posedge clk); #1;
      axi_wvalid = 1'b0; axi_wdata = $urandom;
    end
  endtask

  task automatic wait_rready();
    int n = 0;
    while (!rready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_rd_data", 32'(rready), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end

  initial begin
    int w_before, ar_before, d_before;
    logic [31:0] a, d;
    bit rw;

    resetn = 1'b0; axi_start = 0; axi_rw = 0; axi_addr = '0; axi_wdata = '0; axi_wvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'(0));
    chk("rst_status", 32'({axi_done, axi_err, axi_busy}), 32'(0));
    chk("rst_wready", 32'(axi_wready), 32'(1));
    chk("rst_axi_rdata", axi_rdata, 32'h0);
    chk("rst_addrs", araddr | awaddr | wdata, 32'h0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    // zero-wait load
    slv_mem[32'h1000_0040] = 32'hDEAD_BEEF;
    ref_mem[32'h1000_0040] = 32'hDEAD_BEEF;
    issue(1'b1, 32'h1000_0040, 32'h0, 0, 3);
    wait_idle();
    chk("araddr_held", araddr, 32'h1000_0040);

    // zero-wait store latency
    issue(1'b0, 32'h0000_0044, 32'hCAFE_0044, 0, 3);
    wait_idle();

    // AW stalled three cycles, W immediate
    aw_hold = 3; w_before = w_count; d_before = done_count;
    issue(1'b0, 32'h0000_0040, 32'h1234_5678, 0, -1);
    wait_idle();
    chk("skew_w_beats", 32'(w_count - w_before), 32'(1));
    chk("skew_dones", 32'(done_count - d_before), 32'(1));

    // data arriving two cycles after start
    issue(1'b0, 32'h0000_0080, 32'hA5A5_A5A5, 2, -1);
    wait_idle();

    // second start while the read is in RD_DATA
    r_extra = 4; ar_before = ar_count; d_before = done_count;
    issue(1'b1, 32'h0000_0040, 32'h0, 0, -1);
    wait_rready();
    axi_start = 1'b1; axi_rw = 1'b1; axi_addr = 32'h1000_0040;
    @(posedge clk); #1;
    axi_start = 1'b0;
    wait_idle();
    r_extra = 0;
    chk("busy_start_ar_count", 32'(ar_count - ar_before), 32'(1));
    chk("busy_start_dones", 32'(done_count - d_before), 32'(1));

    // error responses
    issue(1'b0, 32'hF000_0010, 32'h1111_2222, 0, -1);
    wait_idle();
    issue(1'b1, 32'hF000_0020, 32'h0, 0, -1);
    wait_idle();
    chk("idle_after_err", 32'(axi_busy), 32'(0));

    // reset in the middle of a read
    r_extra = 10;
    issue(1'b1, 32'h0000_0080, 32'h0, 0, -1);
    wait_rready();
    #2 resetn = 1'b0;
    #1;
    chk("rst_mid_rready", 32'(rready), 32'(0));
    chk("rst_mid_arvalid", 32'(arvalid), 32'(0));
    chk("rst_mid_busy", 32'(axi_busy), 32'(0));
    chk("rst_mid_rdata", axi_rdata, 32'h0);
    exp_q.delete(); exp_ar_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
    rd_pending = 1'b0; aw_got = 1'b0; w_got = 1'b0; r_extra = 0;
    last_rdata = '0;
    d_before = done_count;
    repeat (2) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_no_done", 32'(done_count - d_before), 32'(0));

    // randomized traffic with random slave stalls
    zero_wait = 1'b0;
    for (int i = 0; i < 60; i++) begin
      a = {($urandom_range(0, 7) == 0) ? 4'hF : 4'h1, 28'h0} | 32'($urandom_range(0, 7) << 2);
      d = $urandom;
      rw = 1'($urandom_range(0, 1));
      issue(rw, a, d, int'($urandom_range(0, 3)), -1);
    end
    wait_idle();
    chk("left_expectations", 32'(exp_q.size() + exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
